// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared widths, state encoding and helpers for the sequential multiplier
package mul_pkg;

  localparam int MUL_W  = 32;
  localparam int PROD_W = 64;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] LAST_CNT = 5'd31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Two's-complement magnitude; -2^31 maps to 32'h8000_0000, which is exact unsigned.
  function automatic logic [MUL_W-1:0] abs_val(input logic [MUL_W-1:0] v);
    return v[MUL_W-1] ? (~v + MUL_W'(1)) : v;
  endfunction

endpackage

// File: rtl/mul_adder33.sv
// rtl/mul_adder33.sv - combinational 32+32 -> 33-bit adder for the ADD step
module mul_adder33
  import mul_pkg::*;
(
  input  logic [MUL_W-1:0] a_i,
  input  logic [MUL_W-1:0] b_i,
  output logic [MUL_W:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/multiplier_seq.sv
// rtl/multiplier_seq.sv - 32x32 shift-add multiplier, 65-cycle latency; MUL_SIGNED_EN adds signed mode
module multiplier_seq
  import mul_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef MUL_SIGNED_EN
  input  logic             signed_op,
`endif
  input  logic [MUL_W-1:0] multiplicand,
  input  logic [MUL_W-1:0] multiplier,
  output logic [MUL_W-1:0] product_hi,
  output logic [MUL_W-1:0] product_lo,
  output logic             busy,
  output logic             done
);

  state_e              state_q, state_d;
  logic [MUL_W-1:0]    mcand_q, mcand_d;
  logic [PROD_W-1:0]   prod_q, prod_d;
  logic                carry_q, carry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MUL_W:0]      sum;
  logic [PROD_W-1:0]   shifted;
  logic                last_shift;
  logic [MUL_W-1:0]    load_mcand;
  logic [MUL_W-1:0]    load_mplier;

  mul_adder33 u_adder (
    .a_i   (prod_q[PROD_W-1:MUL_W]),
    .b_i   (mcand_q),
    .sum_o (sum)
  );

  assign shifted    = {carry_q, prod_q[PROD_W-1:1]};
  assign last_shift = (cnt_q == LAST_CNT);

`ifdef MUL_SIGNED_EN
  logic sign_q, sign_d;
  logic load_sign;

  // Signed mode runs the unsigned engine on magnitudes; the sign is reapplied in the final shift.
  always_comb begin
    load_mcand  = multiplicand;
    load_mplier = multiplier;
    load_sign   = 1'b0;
    if (signed_op) begin
      load_mcand  = abs_val(multiplicand);
      load_mplier = abs_val(multiplier);
      load_sign   = multiplicand[MUL_W-1] ^ multiplier[MUL_W-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_q <= 1'b0;
    end else begin
      sign_q <= sign_d;
    end
  end

  always_comb begin
    sign_d = sign_q;
    if (state_q == IDLE && start) begin
      sign_d = load_sign;
    end
  end
`else
  assign load_mcand  = multiplicand;
  assign load_mplier = multiplier;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     state_d = SHIFT;
      SHIFT:   state_d = last_shift ? DONE : ADD;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ADD) || (state_q == SHIFT);
    done = (state_q == DONE);
  end

  always_comb begin
    mcand_d = mcand_q;
    prod_d  = prod_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = load_mcand;
          prod_d  = {{MUL_W{1'b0}}, load_mplier};
          carry_d = 1'b0;
          cnt_d   = '0;
        end
      end
      ADD: begin
        if (prod_q[0]) begin
          {carry_d, prod_d[PROD_W-1:MUL_W]} = sum;
        end
      end
      SHIFT: begin
        prod_d  = shifted;
        carry_d = 1'b0;
        cnt_d   = cnt_q + CNT_W'(1);
`ifdef MUL_SIGNED_EN
        if (last_shift && sign_q) begin
          prod_d = ~shifted + PROD_W'(1);
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q <= '0;
      prod_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  assign product_hi = prod_q[PROD_W-1:MUL_W];
  assign product_lo = prod_q[MUL_W-1:0];

endmodule

// File: tb/tb_multiplier_seq.sv
// tb/tb_multiplier_seq.sv - directed table-driven bench for multiplier_seq
module tb_multiplier_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] product_hi;
  logic [31:0] product_lo;
  logic        busy;
  logic        done;
`ifdef MUL_SIGNED_EN
  logic        signed_op;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          sgn;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  multiplier_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
`ifdef MUL_SIGNED_EN
    .signed_op    (signed_op),
`endif
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product_hi   (product_hi),
    .product_lo   (product_lo),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    multiplicand = v.a;
    multiplier   = v.b;
`ifdef MUL_SIGNED_EN
    signed_op    = v.sgn;
`endif
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start        = 1'b0;
    multiplicand = ~v.a;
    multiplier   = v.b ^ 32'h5A5A_A5A5;
    cyc      = 1;
    busy_cnt = 0;
    seen     = 1'b0;
    while (cyc <= 100) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s done_seen", tag), 64'(seen), 64'd1);
    check($sformatf("%s latency", tag), 64'(cyc), 64'd65);
    check($sformatf("%s busy_cycles", tag), 64'(busy_cnt), 64'd64);
    check($sformatf("%s busy_at_done", tag), 64'(busy), 64'd0);
    check($sformatf("%s product", tag), {product_hi, product_lo}, v.exp);
    @(negedge clk);
    check($sformatf("%s done_single", tag), 64'(done), 64'd0);
    check($sformatf("%s product_hold", tag), {product_hi, product_lo}, v.exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    rst          = 1'b0;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
`ifdef MUL_SIGNED_EN
    signed_op    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("reset product", {product_hi, product_lo}, 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    rst = 1'b1;

    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001});
    vecs.push_back('{32'h0000_0000, 32'h1234_5678, 1'b0, 64'h0});
    vecs.push_back('{32'h1234_5678, 32'h0000_0000, 1'b0, 64'h0});
    vecs.push_back('{32'h0000_0003, 32'h0000_0005, 1'b0, 64'd15});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE});
    vecs.push_back('{32'h1234_5678, 32'h0000_0010, 1'b0, 64'h0000_0001_2345_6780});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 64'h0000_0000_DEAD_BEEF});
`ifdef MUL_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB});
    vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000});
    vecs.push_back('{32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001});
    vecs.push_back('{32'h0000_0005, 32'hFFFF_FFFD, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1});
`endif

    foreach (vecs[i]) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a long multiply, then a fresh 7 x 9.
    @(negedge clk);
    multiplicand = 32'hFFFF_FFFF;
    multiplier   = 32'hFFFF_FFFF;
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    check("midrun busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset product", {product_hi, product_lo}, 64'd0);
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_vec('{32'd7, 32'd9, 1'b0, 64'd63}, "post_reset");

    // Start held high: operands changed mid-run must not matter, and the
    // next op is only accepted from IDLE after DONE.
    @(negedge clk);
    multiplicand = 32'd3;
    multiplier   = 32'd5;
`ifdef MUL_SIGNED_EN
    signed_op    = 1'b0;
`endif
    start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc = 1;
    while (cyc <= 100) begin
      if (cyc == 10) begin
        multiplicand = 32'd100;
        multiplier   = 32'd100;
      end
      if (done) break;
      @(negedge clk);
      cyc++;
    end
    check("held latency", 64'(cyc), 64'd65);
    check("held product", {product_hi, product_lo}, 64'd15);
    @(negedge clk);
    check("held idle busy", 64'(busy), 64'd0);
    check("held idle done", 64'(done), 64'd0);
    check("held idle product", {product_hi, product_lo}, 64'd15);
    @(negedge clk);
    check("held reaccept busy", 64'(busy), 64'd1);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("second op done", 64'(done), 64'd1);
    check("second op product", {product_hi, product_lo}, 64'd10000);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplier_seq.md
MULTIPLIER_SEQ -- requirements
Module: multiplier_seq

Interface
REQ-001 Parameter: none; operand width fixed at 32 bits, product width 64 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 multiplicand  input  32  multiplicand operand; captured when start is accepted.
REQ-006 multiplier  input  32  multiplier operand; captured when start is accepted.
REQ-007 signed_op  input  1  two's-complement mode select; present only when MUL_SIGNED_EN is defined.
REQ-008 product_hi  output  32  upper half of the 64-bit product register.
REQ-009 product_lo  output  32  lower half of the 64-bit product register.
REQ-010 busy  output  1  high from the cycle after acceptance through the last SHIFT.
REQ-011 done  output  1  one-cycle pulse; product valid and stable while high and after.

Function
REQ-012 States: IDLE, ADD, SHIFT, DONE; no other states are reachable.
REQ-013 IDLE with start=1: latch multiplicand into an internal 32-bit register; load {product_hi,product_lo} = {32'd0, multiplier}; clear carry bit; clear 5-bit count; go to ADD.
REQ-014 IDLE with start=0: hold all registers; product outputs keep the last result.
REQ-015 ADD: if product_lo[0]=1, {carry,product_hi} = product_hi + multiplicand (33-bit sum); else hold; go to SHIFT.
REQ-016 SHIFT: {carry,product_hi,product_lo} shifted right by 1 with 0 into carry; count increments; go to DONE when count was 31, else go to ADD.
REQ-017 DONE: done=1 for exactly this cycle; busy=0; go to IDLE unconditionally.
REQ-018 Latency: done is high in the 65th cycle after the start-accepting edge (1 accept + 32 x (ADD+SHIFT)).
REQ-019 start while busy or in DONE is ignored; it is not queued.
REQ-020 Operands changing after acceptance do not affect the result.
REQ-021 Unsigned result is exact: product = multiplicand x multiplier modulo 2^64, with no overflow possible.
REQ-022 Multiplier of 0 or multiplicand of 0: the full 65-cycle sequence still runs; the result is 64'd0.

Reset
REQ-023 rst=0 forces, without waiting for clk: state=IDLE, product_hi=0, product_lo=0, carry=0, count=0, multiplicand register=0, busy=0, done=0.
REQ-024 Reset mid-operation abandons the multiply; after release the block sits in IDLE and the first rising edge with start=1 begins a fresh operation.

Configuration
REQ-025 Macro MUL_SIGNED_EN defined: the signed_op port exists.
REQ-026 With MUL_SIGNED_EN defined and signed_op=1 at acceptance: operand magnitudes are loaded and the sign XOR is stored; in the final SHIFT the 64-bit result is two's-complement negated when the stored sign is 1.
REQ-027 With MUL_SIGNED_EN defined, -2^31 has magnitude 2^31, which is representable unsigned, so the result is exact.
REQ-028 With MUL_SIGNED_EN defined, latency is unchanged.
REQ-029 MUL_SIGNED_EN undefined: the port and sign logic are absent, and the block is unsigned only.

Structure
REQ-030 Shared package mul_pkg: state enum, MUL_W=32, PROD_W=64, CNT_W=5, LAST_CNT=31.
REQ-031 One sub-module, mul_adder33: combinational 32+32 -> 33-bit adder used in ADD; all sequencing stays in multiplier_seq.

Verification
REQ-032 Reset and idle: rst=0 mid-run at cycle 20 -> all outputs 0 immediately; after release, start with 7 x 9 -> product_lo=63, product_hi=0, done pulse.
REQ-033 Unsigned corner: 32'hFFFFFFFF x 32'hFFFFFFFF -> {hi,lo}=64'hFFFFFFFE_00000001; done in cycle 65; busy high for cycles 1-64.
REQ-034 Ignored start: start=1 held continuously with 3 x 5 and the operands changed to 100 x 100 at cycle 10 -> first result 15; next op accepted only in IDLE after DONE.
REQ-035 Zero operand: 0 x 32'h12345678 -> 64'd0 with full latency and exactly one done pulse.
REQ-036 Signed (MUL_SIGNED_EN defined): -3 x 7 -> 64'hFFFFFFFF_FFFFFFEB; -2^31 x -2^31 -> 64'h40000000_00000000; signed_op=0 with 32'hFFFFFFFF x 2 -> 64'h00000001_FFFFFFFE.
